// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a shared request/ready memory port.
// Latency: branch/jump 3, ALU/store 4, load 5 cycles plus memory waits (branch 2 when BRANCH_IN_DECODE=1).
// Backpressure: MemReq is held until MemReady; MEM_TIMEOUT unanswered request cycles trap with BusErr.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT      = 16,
    parameter bit BRANCH_IN_DECODE = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] OpCode,
    input  logic [5:0] FunctCode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemIsInstr,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUToASel,
    output logic       ALUToBSel,
    output logic       EXTSel,
    output logic [3:0] ALUOpertion,
    output logic [1:0] NPCSel,
    output logic [1:0] RegWriAddSel,
    output logic [1:0] RegWriDatSel,
    output logic [2:0] Load,
    output logic [1:0] Store,
    output logic       InstrDone,
    output logic       IllegalInstr,
    output logic       BusErr
);

    localparam logic [3:0] OP_ADD  = 4'b0001, OP_SUB  = 4'b0010, OP_AND  = 4'b0011, OP_OR   = 4'b0100,
                           OP_SLT  = 4'b0101, OP_SLTU = 4'b0110, OP_NOR  = 4'b0111, OP_SLL  = 4'b1000,
                           OP_SRL  = 4'b1001, OP_SRA  = 4'b1010, OP_SLLV = 4'b1011, OP_SRLV = 4'b1100,
                           OP_LUI  = 4'b1101, OP_XOR  = 4'b1110, OP_SRAV = 4'b1111;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} cls_t;

    typedef struct packed {
        logic       legal;
        cls_t       cls;
        logic       is_bne;
        logic       link;
        logic       jump_reg;
        logic       a_sel;
        logic       b_sel;
        logic       ext;
        logic [3:0] alu_op;
        logic [1:0] wa;
        logic [1:0] wd;
        logic [2:0] load;
        logic [1:0] store;
    } dec_t;

    typedef struct packed {
        logic       req;
        logic       instr;
        logic       wr;
        logic       irw;
        logic       pcw;
        logic       regw;
        logic       a_sel;
        logic       b_sel;
        logic       ext;
        logic [3:0] alu_op;
        logic [1:0] npc;
        logic [1:0] wa;
        logic [1:0] wd;
        logic [2:0] load;
        logic [1:0] store;
        logic       done;
        logic       ill;
        logic       bus;
    } ctl_t;

    state_t        state_q, state_d;
    dec_t          dec;
    ctl_t          ctl;
    logic [CW-1:0] wait_q;
    logic          ill_q, bus_q;
    logic          set_ill, set_bus;
    logic          req_wait, timeout, taken;

    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        dec.ext   = 1'b1;
        dec.cls   = C_ALU;
        case (OpCode)
            6'b000000: begin
                case (FunctCode)
                    6'b100000, 6'b100001: dec.alu_op = OP_ADD;
                    6'b100010, 6'b100011: dec.alu_op = OP_SUB;
                    6'b100100: dec.alu_op = OP_AND;
                    6'b100101: dec.alu_op = OP_OR;
                    6'b100110: dec.alu_op = OP_XOR;
                    6'b100111: dec.alu_op = OP_NOR;
                    6'b101010: dec.alu_op = OP_SLT;
                    6'b101011: dec.alu_op = OP_SLTU;
                    6'b000000: begin dec.alu_op = OP_SLL; dec.a_sel = 1'b1; end
                    6'b000010: begin dec.alu_op = OP_SRL; dec.a_sel = 1'b1; end
                    6'b000011: begin dec.alu_op = OP_SRA; dec.a_sel = 1'b1; end
                    6'b000100: dec.alu_op = OP_SLLV;
                    6'b000110: dec.alu_op = OP_SRLV;
                    6'b000111: dec.alu_op = OP_SRAV;
                    6'b001000: begin dec.cls = C_JUMP; dec.jump_reg = 1'b1; end
                    6'b001001: begin
                        dec.cls      = C_JUMP;
                        dec.jump_reg = 1'b1;
                        dec.link     = 1'b1;
                        dec.wd       = 2'b10;
                    end
                    default: dec.legal = 1'b0;
                endcase
            end
            6'b001000: begin dec.b_sel = 1'b1; dec.alu_op = OP_ADD; dec.wa = 2'b01; end
            6'b001100: begin dec.b_sel = 1'b1; dec.alu_op = OP_AND; dec.wa = 2'b01; dec.ext = 1'b0; end
            6'b001101: begin dec.b_sel = 1'b1; dec.alu_op = OP_OR;  dec.wa = 2'b01; dec.ext = 1'b0; end
            6'b001010: begin dec.b_sel = 1'b1; dec.alu_op = OP_SLT; dec.wa = 2'b01; end
            6'b001111: begin dec.b_sel = 1'b1; dec.alu_op = OP_LUI; dec.wa = 2'b01; end
            6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: begin
                dec.cls    = C_LOAD;
                dec.b_sel  = 1'b1;
                dec.alu_op = OP_ADD;
                dec.wa     = 2'b01;
                dec.wd     = 2'b01;
                case (OpCode)
                    6'b100000: dec.load = 3'b001;
                    6'b100100: dec.load = 3'b010;
                    6'b100001: dec.load = 3'b011;
                    6'b100101: dec.load = 3'b100;
                    default:   dec.load = 3'b000;
                endcase
            end
            6'b101011, 6'b101000, 6'b101001: begin
                dec.cls    = C_STORE;
                dec.b_sel  = 1'b1;
                dec.alu_op = OP_ADD;
                case (OpCode)
                    6'b101000: dec.store = 2'b01;
                    6'b101001: dec.store = 2'b10;
                    default:   dec.store = 2'b00;
                endcase
            end
            6'b000100: begin dec.cls = C_BRANCH; dec.alu_op = OP_SUB; end
            6'b000101: begin dec.cls = C_BRANCH; dec.alu_op = OP_SUB; dec.is_bne = 1'b1; end
            6'b000010: dec.cls = C_JUMP;
            6'b000011: begin dec.cls = C_JUMP; dec.link = 1'b1; dec.wa = 2'b10; dec.wd = 2'b10; end
            default:   dec.legal = 1'b0;
        endcase
        if (!dec.legal) begin
            dec = '0;
        end
    end

    // Ready on the last permitted cycle wins over the timeout.
    assign req_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemReady;
    assign timeout  = (MEM_TIMEOUT != 0) && req_wait && (wait_q == CW'(MEM_TIMEOUT - 1));
    assign taken    = dec.is_bne ? !Zero : Zero;

    always_comb begin
        state_d = state_q;
        set_ill = 1'b0;
        set_bus = 1'b0;
        ctl     = '0;
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ctl.a_sel  = dec.a_sel;
            ctl.b_sel  = dec.b_sel;
            ctl.ext    = dec.ext;
            ctl.alu_op = dec.alu_op;
            ctl.wa     = dec.wa;
            ctl.wd     = dec.wd;
            ctl.load   = dec.load;
            ctl.store  = dec.store;
        end
        case (state_q)
            S_FETCH: begin
                ctl.req   = 1'b1;
                ctl.instr = 1'b1;
                if (MemReady) begin
                    ctl.irw = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    set_bus = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!dec.legal) begin
                    set_ill = 1'b1;
                    state_d = S_TRAP;
                end else if (BRANCH_IN_DECODE && (dec.cls == C_BRANCH)) begin
                    ctl.pcw = 1'b1;
                    ctl.npc = taken ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (dec.cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH: begin
                        ctl.pcw = 1'b1;
                        ctl.npc = taken ? 2'b01 : 2'b00;
                        state_d = S_FETCH;
                    end
                    C_JUMP: begin
                        ctl.pcw  = 1'b1;
                        ctl.npc  = dec.jump_reg ? 2'b11 : 2'b10;
                        ctl.regw = dec.link;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                ctl.req = 1'b1;
                ctl.wr  = (dec.cls == C_STORE);
                if (MemReady) begin
                    if (dec.cls == C_STORE) begin
                        ctl.pcw = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    set_bus = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                ctl.regw = 1'b1;
                ctl.pcw  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
        ctl.done = ctl.pcw;
        ctl.ill  = ill_q;
        ctl.bus  = bus_q;
    end

    // Holding rstn low silences every output, so an aborted request issues no strobe.
    assign {MemReq, MemIsInstr, MemWrite, IRWrite, PCWrite, RegWrite, ALUToASel, ALUToBSel, EXTSel,
            ALUOpertion, NPCSel, RegWriAddSel, RegWriDatSel, Load, Store, InstrDone, IllegalInstr,
            BusErr} = rstn ? ctl : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_wait && (MEM_TIMEOUT != 0)) begin
                wait_q <= wait_q + CW'(1);
            end else begin
                wait_q <= '0;
            end
            if (set_ill) ill_q <= 1'b1;
            if (set_bus) bus_q <= 1'b1;
        end
    end

endmodule
